wb_mem_slave: RTL and testbench

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

---
 rtl/dcpu_wb_pkg.sv | 26 ++
 rtl/wb_mem_array.sv | 37 +++
 rtl/wb_mem_slave.sv | 132 +++++++++++++
 tb/tb_wb_mem_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_wb_pkg.sv
// Shared types and constants for the Wishbone memory slave.
package dcpu_wb_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] LANE_HI  = 4'b1100;
  localparam logic [3:0] LANE_LO  = 4'b0011;
  localparam logic [3:0] LANE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Expand a 4-bit byte-lane select into a 32-bit bit mask (lane b -> bits 8b+7:8b).
  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// The read register zeroes deselected lanes and holds its value between reads;
// only the read register is reset, the storage itself keeps its contents.
module wb_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [3:0]    wr_lanes,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [3:0]    rd_lanes,
  output logic [31:0]   rd_data
);
  import dcpu_wb_pkg::*;

  logic [31:0] mem [DEPTH];

  // Byte-lane write into the addressed word.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Synchronous read with lane masking; an all-zero lane select loads zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[addr] & lane_mask(rd_lanes);
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone memory slave: request latching, wait-state down-counter and response FSM.
// Optional macro WB_MEM_SLAVE_ADDR_ERR_EN: word indices >= DEPTH answer with an
// error pulse instead of aliasing onto the low DEPTH words.
//
// state   | meaning
// IDLE    | no transaction; a request here is latched
// WAIT    | counting down wait states; cyc low aborts
// RESP    | one-cycle ack/err, memory written or read on entry
module wb_mem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic [3:0]  i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);
  import dcpu_wb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  wb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [29:0]      lat_idx;
  logic             lat_we;
  logic [3:0]       lat_stb;
  logic [31:0]      lat_dat;
  logic             ack_q;

  logic             req;
  logic             in_idle;
  logic             go_resp;
  logic             oob;
  logic [29:0]      sel_idx;
  logic             sel_we;
  logic [3:0]       sel_stb;
  logic [31:0]      sel_dat;

  // In IDLE the bus is used directly so a zero-wait access completes on the sampling edge.
  always_comb begin
    req     = i_wb_cyc && (i_wb_stb != 4'b0000);
    in_idle = (state == ST_IDLE);
    sel_idx = in_idle ? i_wb_addr[31:2] : lat_idx;
    sel_we  = in_idle ? i_wb_we         : lat_we;
    sel_stb = in_idle ? i_wb_stb        : lat_stb;
    sel_dat = in_idle ? i_wb_dat        : lat_dat;
    go_resp = (in_idle && req && (WAIT_STATES == 0)) ||
              ((state == ST_WAIT) && i_wb_cyc && (cnt == CNT_W'(1)));
`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
    oob     = (sel_idx[29:AW] != '0);
`else
    oob     = 1'b0;
`endif
  end

  wb_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .addr      (sel_idx[AW-1:0]),
    .wr_en     (go_resp && sel_we && !oob),
    .wr_lanes  (sel_stb),
    .wr_data   (sel_dat),
    .rd_en     (go_resp && !sel_we),
    .rd_lanes  (oob ? 4'b0000 : sel_stb),
    .rd_data   (o_wb_dat)
  );

`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
  logic err_q;
  assign o_wb_err = err_q;
  logic unused_bits;
  assign unused_bits = ^i_wb_addr[1:0];
`else
  assign o_wb_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{i_wb_addr[1:0], sel_idx[29:AW]};
`endif

  assign o_wb_ack = ack_q;

  // Transaction FSM with latched request, wait down-counter and registered ack/err.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_we  <= 1'b0;
      lat_stb <= '0;
      lat_dat <= '0;
      ack_q   <= 1'b0;
`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= go_resp && !oob;
`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
      err_q <= go_resp && oob;
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_idx <= i_wb_addr[31:2];
            lat_we  <= i_wb_we;
            lat_stb <= i_wb_stb;
            lat_dat <= i_wb_dat;
            cnt     <= WAIT_LOAD;
            state   <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Scoreboard bench for wb_mem_slave: two instances (0 and 3 wait states) driven
// one at a time; a behavioural memory model predicts each response.
module tb_wb_mem_slave;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic [31:0] addr  [2];
  logic        cyc   [2];
  logic [3:0]  stb   [2];
  logic        we    [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdat  [2];
  logic        ack   [2];
  logic        err   [2];

  always #5 clk = ~clk;

  wb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n[0]), .i_wb_addr(addr[0]), .i_wb_cyc(cyc[0]),
    .i_wb_stb(stb[0]), .i_wb_we(we[0]), .i_wb_dat(wdat[0]),
    .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]));

  wb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n[1]), .i_wb_addr(addr[1]), .i_wb_cyc(cyc[1]),
    .i_wb_stb(stb[1]), .i_wb_we(we[1]), .i_wb_dat(wdat[1]),
    .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]));

  typedef struct {
    int          dut;
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          resp_cnt [2];
  logic [31:0] ref_mem [2][DEPTH];
  bit          known   [2][DEPTH];
  logic [31:0] last_dat [2];
  bit          last_ok  [2];

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the byte-lane rules to an array of words.
  task automatic model(input int d, input logic [31:0] a, input bit w,
                       input logic [3:0] s, input logic [31:0] wd);
    exp_t   e;
    longint idx;
    int     i;
    logic [31:0] word;
    idx       = longint'(a >> 2);
    e.dut     = d;
    e.is_err  = 1'b0;
`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
    if (idx >= DEPTH) begin
      e.is_err = 1'b1;
      if (!w) begin last_dat[d] = 32'h0; last_ok[d] = 1'b1; end
      e.chk_dat = last_ok[d];
      e.dat     = last_dat[d];
      sb.push_back(e);
      return;
    end
`endif
    i = int'(idx % DEPTH);
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[d][i][8*b +: 8] = wd[8*b +: 8];
      if (s == 4'hF) known[d][i] = 1'b1;
    end else begin
      word = ref_mem[d][i];
      for (int b = 0; b < 4; b++)
        last_dat[d][8*b +: 8] = s[b] ? word[8*b +: 8] : 8'h00;
      last_ok[d] = known[d][i];
    end
    e.chk_dat = last_ok[d];
    e.dat     = last_dat[d];
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per response cycle.
  task automatic mon(input int d);
    exp_t e;
    if (ack[d] || err[d]) begin
      resp_cnt[d]++;
      check("ack_err_exclusive", {31'b0, ack[d] & err[d]}, 32'h0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: dut%0d ack=%b err=%b, expected no response", d, ack[d], err[d]);
      end else begin
        e = sb.pop_front();
        check("resp_dut", d, e.dut);
        check("resp_err", {31'b0, err[d]}, {31'b0, e.is_err});
        if (e.chk_dat) check("resp_dat", rdat[d], e.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One complete transaction, leaves the request asserted (back-to-back capable).
  task automatic xact(input int d, input logic [31:0] a, input bit w,
                      input logic [3:0] s, input logic [31:0] wd);
    int n;
    int lat_exp;
    lat_exp = ws(d) + 1 + ((ack[d] || err[d]) ? 1 : 0);
    model(d, a, w, s, wd);
    addr[d] = a; we[d] = w; stb[d] = s; wdat[d] = wd; cyc[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 40);
    check("latency", n, lat_exp);
    if (!(ack[d] || err[d]) && sb.size() != 0) void'(sb.pop_back());
  endtask

  task automatic idle(input int d);
    cyc[d] = 1'b0;
    stb[d] = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 4'h0; we[d] = 1'b0;
      addr[d] = '0; wdat[d] = '0; resp_cnt[d] = 0;
      last_dat[d] = 32'h0; last_ok[d] = 1'b1;
      for (int i = 0; i < DEPTH; i++) known[d][i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", {31'b0, ack[d]}, 32'h0);
      check("reset_err", {31'b0, err[d]}, 32'h0);
      check("reset_dat", rdat[d], 32'h0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      // basic write then read
      xact(d, 32'h10, 1, 4'hF, 32'hDEADBEEF); idle(d);
      xact(d, 32'h10, 0, 4'hF, 32'h0);        idle(d);
      // halfword lanes
      xact(d, 32'h20, 1, 4'hF, 32'h11223344); idle(d);
      xact(d, 32'h20, 1, 4'b0011, 32'hAAAABBBB); idle(d);
      xact(d, 32'h20, 0, 4'hF, 32'h0); idle(d);
      xact(d, 32'h20, 0, 4'b1100, 32'h0); idle(d);
      // cyc with zero strobes is not a request
      c0 = resp_cnt[d];
      addr[d] = 32'h20; we[d] = 1'b1; stb[d] = 4'h0; cyc[d] = 1'b1;
      repeat (8) @(negedge clk);
      check("no_req_stb0", resp_cnt[d], c0);
      idle(d);
      // preload a working set, then random traffic with occasional back-to-back
      for (int i = 0; i < 16; i++) begin
        xact(d, 32'h100 + 32'(4*i), 1, 4'hF, $urandom);
        if ($urandom_range(0, 1) == 1) idle(d);
      end
      for (int k = 0; k < 40; k++) begin
        xact(d, 32'h100 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
        if ($urandom_range(0, 2) == 0) idle(d);
      end
      idle(d);
      // out-of-range index: error or alias onto word 0
      xact(d, 32'h0, 1, 4'hF, 32'h0BADF00D); idle(d);
      xact(d, 32'h1000, 1, 4'hF, 32'hC0FFEE00); idle(d);
      xact(d, 32'h0, 0, 4'hF, 32'h0); idle(d);
      xact(d, 32'h1000, 0, 4'hF, 32'h0); idle(d);
    end

    // abort during wait states
    xact(1, 32'h40, 1, 4'hF, 32'h5A5A1234); idle(1);
    c0 = resp_cnt[1];
    addr[1] = 32'h40; we[1] = 1'b1; stb[1] = 4'hF; wdat[1] = 32'hFFFF0000; cyc[1] = 1'b1;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 4'h0;
    repeat (8) @(negedge clk);
    check("abort_no_ack", resp_cnt[1], c0);
    xact(1, 32'h40, 0, 4'hF, 32'h0); idle(1);

    // reset during wait states: outputs clear at once, write is dropped
    xact(1, 32'h48, 1, 4'hF, 32'h600DCAFE); idle(1);
    xact(1, 32'h20, 0, 4'hF, 32'h0); idle(1);
    addr[1] = 32'h48; we[1] = 1'b1; stb[1] = 4'hF; wdat[1] = 32'h12345678; cyc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("rst_mid_ack", {31'b0, ack[1]}, 32'h0);
    check("rst_mid_err", {31'b0, err[1]}, 32'h0);
    check("rst_mid_dat", rdat[1], 32'h0);
    cyc[1] = 1'b0; stb[1] = 4'h0;
    last_dat[1] = 32'h0; last_ok[1] = 1'b1;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    xact(1, 32'h48, 0, 4'hF, 32'h0); idle(1);
    xact(1, 32'h10, 0, 4'hF, 32'h0); idle(1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
